// File: rtl/filter_bank_scheduler.sv
// filter_bank_scheduler: read scheduler for the filter bank's buffers.
// Issues at most one one-hot read grant per cycle. Requesters are served
// round-robin, and one requester may take up to MAX_BURST consecutive grants.
// Grants are gated on downstream credits. A drain handshake lets the phase
// switch only once every buffer and the downstream pipeline are empty.
// Optional build macro FILTER_SCHED_HOME_PRIORITY_EN: while home_urgent is
// high, home buffer 0 takes priority over burst and rotation state.
module filter_bank_scheduler #(
  parameter int NUM_FILTER   = 7,
  parameter int IDX_WIDTH    = 3,
  parameter int MAX_BURST    = 4,
  parameter int CREDIT_MAX   = 16,
  parameter int CREDIT_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FILTER-1:0]   buffer_not_empty,
  input  logic                    credit_return,
  input  logic                    drain_req,
  input  logic                    home_urgent,
  output logic [NUM_FILTER-1:0]   grant,
  output logic                    grant_valid,
  output logic [IDX_WIDTH-1:0]    grant_idx,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    drain_done,
  output logic                    busy
);

  localparam int BURST_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [BURST_WIDTH-1:0]  BURST_LIMIT = BURST_WIDTH'(MAX_BURST);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_MAX);
  localparam logic [IDX_WIDTH-1:0]    LAST_RESET  = IDX_WIDTH'(NUM_FILTER - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_WIDTH-1:0]    last_idx, last_idx_nxt;
  logic [BURST_WIDTH-1:0]  burst_cnt, burst_cnt_nxt;
  logic [CREDIT_WIDTH-1:0] credits_nxt;

  logic                    grant_allowed;
  logic                    can_continue;
  logic                    rot_found;
  logic [IDX_WIDTH-1:0]    rot_idx;
  logic                    sel_valid;
  logic                    sel_continue;
  logic [IDX_WIDTH-1:0]    sel_idx;

`ifndef FILTER_SCHED_HOME_PRIORITY_EN
  logic unused_home_urgent;
  assign unused_home_urgent = home_urgent;
`endif

  // Rotation scan: first non-empty buffer after last_idx, wrapping; last_idx itself is visited last
  always_comb begin
    int unsigned pos;
    rot_found = 1'b0;
    rot_idx   = '0;
    pos       = 0;
    for (int unsigned k = 1; k <= NUM_FILTER; k++) begin
      pos = 32'(last_idx) + k;
      if (pos >= NUM_FILTER) pos = pos - NUM_FILTER;
      if (!rot_found && buffer_not_empty[IDX_WIDTH'(pos)]) begin
        rot_found = 1'b1;
        rot_idx   = IDX_WIDTH'(pos);
      end
    end
  end

  // Candidate selection: home priority (optional), then burst continuation, then rotation
  always_comb begin
    grant_allowed = !rst && (state != ST_DONE) && (credits != '0);
    can_continue  = (burst_cnt != '0) && buffer_not_empty[last_idx] &&
                    (burst_cnt < BURST_LIMIT);
    sel_valid     = 1'b0;
    sel_continue  = 1'b0;
    sel_idx       = '0;
    if (grant_allowed) begin
`ifdef FILTER_SCHED_HOME_PRIORITY_EN
      if (home_urgent && buffer_not_empty[0]) begin
        sel_valid    = 1'b1;
        sel_idx      = '0;
        sel_continue = (last_idx == '0);
      end else
`endif
      if (can_continue) begin
        sel_valid    = 1'b1;
        sel_idx      = last_idx;
        sel_continue = 1'b1;
      end else if (rot_found) begin
        // Rotation wrapping back to last_idx is a fresh burst, not a continuation
        sel_valid    = 1'b1;
        sel_idx      = rot_idx;
        sel_continue = 1'b0;
      end
    end
  end

  // Grant outputs decoded from the selected candidate
  always_comb begin
    grant = '0;
    if (sel_valid) grant[sel_idx] = 1'b1;
    grant_valid = sel_valid;
    grant_idx   = sel_idx;
  end

  // Burst/last-index bookkeeping; the count saturates so a long urgent home run cannot wrap
  always_comb begin
    last_idx_nxt  = last_idx;
    burst_cnt_nxt = '0;
    if (sel_valid) begin
      last_idx_nxt = sel_idx;
      if (sel_continue) begin
        burst_cnt_nxt = (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 1'b1;
      end else begin
        burst_cnt_nxt = BURST_WIDTH'(1);
      end
    end
  end

  // Credit counter: a grant consumes a slot, a return frees one, and returns saturate at full
  always_comb begin
    credits_nxt = credits;
    case ({sel_valid, credit_return})
      2'b10:   credits_nxt = credits - 1'b1;
      2'b01:   if (credits != CREDIT_FULL) credits_nxt = credits + 1'b1;
      default: credits_nxt = credits;
    endcase
  end

  // Drain FSM next state: DONE needs empty buffers and full credits in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req) begin
          state_nxt = ST_RUN;
        end else if ((buffer_not_empty == '0) && (credits == CREDIT_FULL)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  if (!drain_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      last_idx  <= LAST_RESET;
      burst_cnt <= '0;
      credits   <= CREDIT_FULL;
    end else begin
      state     <= state_nxt;
      last_idx  <= last_idx_nxt;
      burst_cnt <= burst_cnt_nxt;
      credits   <= credits_nxt;
    end
  end

  assign drain_done = (state == ST_DONE);
  assign busy       = (|buffer_not_empty) || (credits != CREDIT_FULL);

endmodule

// File: tb/tb_filter_bank_scheduler.sv
// tb_filter_bank_scheduler: scoreboard bench for filter_bank_scheduler.
// The bench keeps its own buffer occupancy counts and derives
// buffer_not_empty from them. A reference model expresses the scheduling
// rules with plain integers. Each stimulus cycle pushes the expected outputs
// into a queue, and a monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_filter_bank_scheduler;

  localparam int NF = 7;
  localparam int IW = 3;
  localparam int MB = 4;
  localparam int CM = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] bne = '0;
  logic          credit_return = 1'b0;
  logic          drain_req = 1'b0;
  logic          home_urgent = 1'b0;
  logic [NF-1:0] grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [CW-1:0] credits;
  logic          drain_done;
  logic          busy;

  always #5 clk = ~clk;

  filter_bank_scheduler #(
    .NUM_FILTER  (NF),
    .IDX_WIDTH   (IW),
    .MAX_BURST   (MB),
    .CREDIT_MAX  (CM),
    .CREDIT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .buffer_not_empty(bne),
    .credit_return   (credit_return),
    .drain_req       (drain_req),
    .home_urgent     (home_urgent),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .grant_idx       (grant_idx),
    .credits         (credits),
    .drain_done      (drain_done),
    .busy            (busy)
  );

  typedef struct {
    int g;      // expected granted index, -1 for none
    int cred;
    bit done;
    bit busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   occ[NF];
  int   m_last, m_burst, m_cred, m_st;   // m_st: 0 run, 1 drain, 2 done
  bit   home_mode;

  // Stimulus knobs
  int   arr_pct  = 0;
  int   ret_mode = 0;   // 0 never, 1 always, 2 random when outstanding, 3 random any time
  bit   drain_v = 1'b0, urg_v = 1'b0, rst_v = 1'b0;

  initial begin
`ifdef FILTER_SCHED_HOME_PRIORITY_EN
    home_mode = 1'b1;
`else
    home_mode = 1'b0;
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = NF - 1;
    m_burst = 0;
    m_cred  = CM;
    m_st    = 0;
  endtask

  task automatic cycle();
    int   g;
    bit   cont;
    bit   ret;
    bit   any;
    exp_t e;
    @(posedge clk);
    #1;
    if (arr_pct > 0)
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 99) < arr_pct) occ[i]++;
    case (ret_mode)
      0:       ret = 1'b0;
      1:       ret = 1'b1;
      2:       ret = (m_cred < CM) && ($urandom_range(0, 1) == 1);
      default: ret = ($urandom_range(0, 9) < 3);
    endcase
    any = 1'b0;
    for (int i = 0; i < NF; i++) begin
      bne[i] = (occ[i] > 0);
      if (occ[i] > 0) any = 1'b1;
    end
    rst           = rst_v;
    credit_return = ret;
    drain_req     = drain_v;
    home_urgent   = urg_v;

    g    = -1;
    cont = 1'b0;
    if (!rst_v && m_st != 2 && m_cred > 0) begin
      if (home_mode && urg_v && occ[0] > 0) begin
        g    = 0;
        cont = (m_last == 0);
      end else if (m_burst > 0 && m_burst < MB && occ[m_last] > 0) begin
        g    = m_last;
        cont = 1'b1;
      end else begin
        for (int k = 1; k <= NF; k++)
          if (g < 0 && occ[(m_last + k) % NF] > 0) g = (m_last + k) % NF;
      end
    end
    e.g    = g;
    e.cred = m_cred;
    e.done = (m_st == 2);
    e.busy = any || (m_cred != CM);
    sbq.push_back(e);

    if (rst_v) begin
      model_reset();
    end else begin
      case (m_st)
        0: if (drain_v) m_st = 1;
        1: if (!drain_v) m_st = 0;
           else if (!any && m_cred == CM) m_st = 2;
        default: if (!drain_v) m_st = 0;
      endcase
      if (g >= 0) begin
        m_burst = cont ? m_burst + 1 : 1;
        m_last  = g;
        occ[g]--;
        m_cred--;
      end else begin
        m_burst = 0;
      end
      if (ret && m_cred < CM) m_cred++;
    end
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("grant_valid", int'(grant_valid), (e.g >= 0) ? 1 : 0);
        chk("grant_idx",   int'(grant_idx),   (e.g >= 0) ? e.g : 0);
        chk("grant",       int'(grant),       (e.g >= 0) ? (1 << e.g) : 0);
        chk("credits",     int'(credits),     e.cred);
        chk("drain_done",  int'(drain_done),  int'(e.done));
        chk("busy",        int'(busy),        int'(e.busy));
      end
    end
  end

  initial begin
    for (int i = 0; i < NF; i++) occ[i] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();

    // All buffers busy, returns every cycle: bursts of four, rotating
    for (int i = 0; i < NF; i++) occ[i] = 1000;
    ret_mode = 1;
    repeat (40) cycle();

    // Buffers 0 and 3 only; buffer 3 re-granted alone with restarted bursts
    rst_v = 1'b1; cycle(); rst_v = 1'b0;
    for (int i = 0; i < NF; i++) occ[i] = 0;
    occ[0] = 2;
    occ[3] = 1000;
    repeat (20) cycle();

    // No returns: exactly CREDIT_MAX grants, then one pulse gives one more
    for (int i = 0; i < NF; i++) occ[i] = 1000;
    ret_mode = 0;
    repeat (20) cycle();
    ret_mode = 1; cycle();
    ret_mode = 0; repeat (4) cycle();

    // Drain with buffered data and outstanding credits, new data while done
    for (int i = 0; i < NF; i++) occ[i] = 0;
    ret_mode = 1;
    repeat (13) cycle();
    occ[1] = 3;
    occ[5] = 2;
    ret_mode = 0;
    repeat (2) cycle();
    drain_v  = 1'b1;
    ret_mode = 1;
    repeat (40) cycle();
    occ[2] = 3;
    repeat (4) cycle();
    drain_v = 1'b0;
    repeat (10) cycle();

    // Reset in the middle of a burst with credits consumed
    for (int i = 0; i < NF; i++) occ[i] = 0;
    repeat (20) cycle();
    for (int i = 0; i < NF; i++) occ[i] = 1000;
    rst_v = 1'b1; cycle(); rst_v = 1'b0;
    ret_mode = 0;
    repeat (6) cycle();
    occ[0] = 0;
    occ[1] = 0;
    rst_v = 1'b1; cycle(); rst_v = 1'b0;
    repeat (5) cycle();

    // Home urgency during a burst on buffer 4
    for (int i = 0; i < NF; i++) occ[i] = 0;
    occ[4]   = 50;
    ret_mode = 1;
    repeat (20) cycle();
    occ[0] = 20;
    urg_v  = 1'b1;
    repeat (8) cycle();
    urg_v = 1'b0;
    repeat (8) cycle();

    // Randomized traffic
    for (int i = 0; i < NF; i++) occ[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      arr_pct = ((n / 300) % 2 == 1) ? 12 : 3;
      if ($urandom_range(0, 99) < 2) drain_v = !drain_v;
      urg_v    = ($urandom_range(0, 99) < 20);
      rst_v    = ($urandom_range(0, 499) == 0);
      ret_mode = ($urandom_range(0, 9) == 0) ? 3 : 2;
      cycle();
    end
    arr_pct = 0;
    rst_v   = 1'b0;
    urg_v   = 1'b0;
    drain_v = 1'b0;
    repeat (5) cycle();

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
